// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for a 5-stage pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB).
//   - Load-use hazard between a load in EX and its consumer in ID: one bubble.
//   - Taken branch / jump resolved in ID: flush IF/ID.
//   - Multi-cycle data memory (req/ack): freeze the whole pipe until ack.
//   - Holds the pipe idle until start_i, counts stall cycles, and traps a
//     hung memory as a sticky error that only reset clears.
//
// Ports
//   clk_i, rst_n_i              clock (rising edge), async active-low reset
//   start_i                     leave IDLE and begin execution
//   IDRegRs_i/IDRegRt_i         source registers of the instruction in ID
//   IDUsesRt_i                  ID instruction actually reads rt
//   EXMemRead_i/EXRegRt_i       load in EX and its destination register
//   Branch_i/Jump_i             taken branch / jump resolved in ID
//   MEMAccess_i, dmem_ack_i     MEM-stage access and memory completion
//   dmem_req_o                  data memory request
//   PCWrite_o, IFIDWrite_o      PC / IF_ID load enables
//   IFIDFlush_o, IDEXBubble_o   IF_ID clear, zero controls entering ID_EX
//   PipeStall_o                 hold ID_EX, EX_MEM, MEM_WB
//   err_o                       sticky memory timeout
//   stall_cnt_o                 saturating count of PCWrite_o=0 cycles in RUN/MEM_WAIT
//   state_dbg_o                 current FSM state (IDLE=0 RUN=1 MEM_WAIT=2 ERROR=3)
//
// Memory handshake: dmem_req_o is a request level. Once raised for an access
// it stays high until the cycle in which dmem_ack_i is seen (ack may come in
// the same cycle as the request); the access completes on that cycle's edge.
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 32,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [4:0]       IDRegRs_i,
  input  logic [4:0]       IDRegRt_i,
  input  logic             IDUsesRt_i,
  input  logic             EXMemRead_i,
  input  logic [4:0]       EXRegRt_i,
  input  logic             Branch_i,
  input  logic             Jump_i,
  input  logic             MEMAccess_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             PipeStall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [TIMEOUT_W-1:0] timer;
  logic                 load_use;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(TIMEOUT);

  // $0 is never a real dependency, so a load targeting it never stalls.
  assign load_use = EXMemRead_i && (EXRegRt_i != 5'd0) &&
                    ((EXRegRt_i == IDRegRs_i) ||
                     (IDUsesRt_i && (EXRegRt_i == IDRegRt_i)));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    dmem_req_o   = 1'b0;
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IFIDFlush_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    PipeStall_o  = 1'b0;
    err_o        = 1'b0;

    case (state)
      IDLE: begin
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        IFIDFlush_o  = 1'b1;
        IDEXBubble_o = 1'b1;
        if (start_i) state_next = RUN;
      end

      RUN, MEM_WAIT: begin
        // In MEM_WAIT the request is held regardless; in RUN it follows MEM.
        dmem_req_o = (state == MEM_WAIT) || MEMAccess_i;
        if (dmem_req_o && !dmem_ack_i) begin
          // Memory still busy: freeze everything in place.
          PCWrite_o   = 1'b0;
          IFIDWrite_o = 1'b0;
          PipeStall_o = 1'b1;
          if (state == RUN) begin
            state_next = MEM_WAIT;
          end else if (timer == TIMEOUT_VAL) begin
            state_next = ERROR;
          end
        end else begin
          // Pipe advances this cycle; remaining hazards resolved in priority.
          state_next = RUN;
          if (load_use) begin
            // Branch/jump in ID is ignored here; it is re-evaluated next cycle.
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
          end else if (Branch_i || Jump_i) begin
            IFIDFlush_o = 1'b1;
          end
        end
      end

      ERROR: begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        PipeStall_o = 1'b1;
        err_o       = 1'b1;
      end

      default: state_next = IDLE;
    endcase
  end

  // timer holds the number of cycles the current access has waited without ack;
  // the RUN cycle that raised the request counts as the first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer <= '0;
    end else if (state == RUN && state_next == MEM_WAIT) begin
      timer <= TIMEOUT_W'(1);
    end else if (state == MEM_WAIT && state_next == MEM_WAIT) begin
      timer <= timer + TIMEOUT_W'(1);
    end else begin
      timer <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if ((state == RUN || state == MEM_WAIT) && !PCWrite_o &&
                 (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  assign state_dbg_o = state;

endmodule
